// File: rtl/ht_stf_seq.sv
// ht_stf_seq
// Plays the 16-entry HT-STF sample ROM as a streaming I/Q burst of
// 16*N_REP samples behind a valid/ready output register. The ROM is read
// combinationally at rom_addr, and each sample is captured into m_tdata
// when it is first presented. A captured sample then holds until
// downstream accepts it.
module ht_stf_seq #(
  parameter int N_REP = 5            // STF periods per burst, legal 1..7
) (
  input  logic        clk,
  input  logic        phy_tx_arestn,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index of the final sample in the burst; m_tlast is loaded with the
  // sample whose index matches it.
  localparam logic [6:0] LP_LAST_IDX = 7'(16 * N_REP - 1);

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_idx, w_idx_nxt;
  logic [31:0] r_tdata, w_tdata_nxt;
  logic        r_tvalid, w_tvalid_nxt;
  logic        r_tlast, w_tlast_nxt;
  logic        r_done, w_done_nxt;
  logic        w_hs;

  assign w_hs = r_tvalid & m_tready;

  // Next-state and next-output logic. abort wins over start and over a
  // handshake in the same cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_done_nxt   = 1'b0;

    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = 7'd0;
      w_tvalid_nxt = 1'b0;
      w_tlast_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // idx is 0 in IDLE, so rom_dout already shows entry 0.
            w_tdata_nxt  = rom_dout;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b0;             // a burst is never 1 sample long
            w_idx_nxt    = 7'd1;
            w_state_nxt  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            if (r_tlast) begin
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
              w_done_nxt   = 1'b1;
              w_idx_nxt    = 7'd0;
              w_state_nxt  = ST_IDLE;
            end else begin
              // rom_addr follows idx[3:0], so the address wraps 15->0 on
              // its own while idx[6:4] counts periods.
              w_tdata_nxt = rom_dout;
              w_tlast_nxt = (r_idx == LP_LAST_IDX);
              w_idx_nxt   = r_idx + 7'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared as soon as reset is asserted.
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      r_state  <= ST_IDLE;
      r_idx    <= 7'd0;
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register updates from
      // the values computed before the edge.
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign rom_addr = r_idx[3:0];
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;

endmodule

// File: tb/tb_ht_stf_seq.sv
// tb_ht_stf_seq
// Directed bench for ht_stf_seq. Three instances (N_REP = 5, 1 and 7) share
// the clock, reset, abort and m_tready. Each instance has its own start and
// its own copy of the ROM image. Stimulus changes and output sampling both
// happen 1 ns after the rising edge.
module tb_ht_stf_seq;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        abort;
  logic        m_tready;
  logic        st [NI];
  logic [3:0]  ra [NI];
  logic [31:0] rd [NI];
  logic [31:0] td [NI];
  logic        tv [NI];
  logic        tl [NI];
  logic        bz [NI];
  logic        dn [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bench copy of the HT-STF ROM. Entries 0 and 4 carry the reference
  // values, and every entry is distinct so that an addressing slip shows up.
  function automatic logic [31:0] rom_val(input logic [3:0] a);
    case (a)
      4'd0:    rom_val = 32'h02D402D4;
      4'd1:    rom_val = 32'hF7E2001F;
      4'd2:    rom_val = 32'hFF33FB23;
      4'd3:    rom_val = 32'h08CCFF33;
      4'd4:    rom_val = 32'h05A80000;
      4'd5:    rom_val = 32'h08CBFF34;
      4'd6:    rom_val = 32'hFF34FB22;
      4'd7:    rom_val = 32'hF7E10020;
      4'd8:    rom_val = 32'h02D302D5;
      4'd9:    rom_val = 32'h001FF7E2;
      4'd10:   rom_val = 32'hFB23FF33;
      4'd11:   rom_val = 32'hFF3308CC;
      4'd12:   rom_val = 32'h000005A8;
      4'd13:   rom_val = 32'hFF3208CD;
      4'd14:   rom_val = 32'hFB22FF34;
      default: rom_val = 32'h0020F7E1;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int REPS = (g == 0) ? 5 : ((g == 1) ? 1 : 7);
    assign rd[g] = rom_val(ra[g]);
    ht_stf_seq #(.N_REP(REPS)) u_dut (
      .clk           (clk),
      .phy_tx_arestn (arst_n),
      .start         (st[g]),
      .abort         (abort),
      .rom_addr      (ra[g]),
      .rom_dout      (rd[g]),
      .m_tdata       (td[g]),
      .m_tvalid      (tv[g]),
      .m_tready      (m_tready),
      .m_tlast       (tl[g]),
      .busy          (bz[g]),
      .done          (dn[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns every instance to IDLE between scenarios.
  task automatic cleanup();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // Runs one burst on instance s with m_tready held high and checks every
  // presented sample, followed by the done cycle.
  task automatic burst_full(input int s, input int n);
    m_tready = 1'b1;
    st[s] = 1'b1;
    tick();
    st[s] = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("i%0d_valid[%0d]", s, k), 32'(tv[s]), 32'd1);
      check($sformatf("i%0d_data[%0d]", s, k), td[s], rom_val(4'(k)));
      check($sformatf("i%0d_last[%0d]", s, k), 32'(tl[s]), 32'(k == n - 1));
      check($sformatf("i%0d_busy[%0d]", s, k), 32'(bz[s]), 32'd1);
      check($sformatf("i%0d_done[%0d]", s, k), 32'(dn[s]), 32'd0);
      check($sformatf("i%0d_addr[%0d]", s, k), 32'(ra[s]), 32'((k + 1) % 16));
      if (s == 0 && k == 0)  check("nom_sample0",  td[s], 32'h02D402D4);
      if (s == 0 && k == 4)  check("nom_sample4",  td[s], 32'h05A80000);
      if (s == 0 && k == 16) check("nom_sample16", td[s], 32'h02D402D4);
      tick();
    end
    check($sformatf("i%0d_done_pulse", s), 32'(dn[s]), 32'd1);
    check($sformatf("i%0d_busy_end", s), 32'(bz[s]), 32'd0);
    check($sformatf("i%0d_valid_end", s), 32'(tv[s]), 32'd0);
    tick();
    check($sformatf("i%0d_done_once", s), 32'(dn[s]), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          hs;
    int          cyc;
    int          dcnt;
    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;

    arst_n   = 1'b0;
    abort    = 1'b0;
    m_tready = 1'b0;
    foreach (st[i]) st[i] = 1'b0;

    // Reset state, sampled while reset is still asserted.
    #7;
    check("rst_valid", 32'(tv[0]), 32'd0);
    check("rst_data",  td[0],      32'd0);
    check("rst_last",  32'(tl[0]), 32'd0);
    check("rst_busy",  32'(bz[0]), 32'd0);
    check("rst_done",  32'(dn[0]), 32'd0);
    check("rst_addr",  32'(ra[0]), 32'd0);
    #5 arst_n = 1'b1;
    repeat (9) tick();

    // Nominal 80-sample burst.
    burst_full(0, 80);

    // Backpressure: the accepted sequence must match the nominal one.
    cleanup();
    m_tready = 1'b0;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    hs = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = 32'd0;
    prev_l = 1'b0;
    while (hs < 80 && cyc < 2000) begin
      m_tready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        check($sformatf("bp_hold_data[%0d]", cyc), td[0], prev_d);
        check($sformatf("bp_hold_last[%0d]", cyc), 32'(tl[0]), 32'(prev_l));
      end
      check($sformatf("bp_valid[%0d]", cyc), 32'(tv[0]), 32'd1);
      check($sformatf("bp_data[%0d]", hs), td[0], rom_val(4'(hs)));
      check($sformatf("bp_last[%0d]", hs), 32'(tl[0]), 32'(hs == 79));
      check($sformatf("bp_done[%0d]", cyc), 32'(dn[0]), 32'd0);
      prev_stall = tv[0] & ~m_tready;
      prev_d = td[0];
      prev_l = tl[0];
      if (m_tready) hs++;
      tick();
      cyc++;
    end
    check("bp_handshakes", 32'(hs), 32'd80);
    check("bp_done_pulse", 32'(dn[0]), 32'd1);
    m_tready = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dcnt += int'(dn[0]);
    end
    check("bp_single_done", 32'(dcnt), 32'd0);

    // Abort while the 37th sample is presented, with a same-cycle handshake.
    cleanup();
    m_tready = 1'b1;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (36) tick();
    check("ab_sample36", td[0], rom_val(4'd4));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(tv[0]), 32'd0);
    check("ab_last",  32'(tl[0]), 32'd0);
    check("ab_done",  32'(dn[0]), 32'd0);
    check("ab_busy",  32'(bz[0]), 32'd0);
    check("ab_addr",  32'(ra[0]), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dcnt += int'(dn[0]) + int'(tv[0]);
    end
    check("ab_quiet", 32'(dcnt), 32'd0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    check("ab_restart_valid", 32'(tv[0]), 32'd1);
    check("ab_restart_data",  td[0], 32'h02D402D4);
    check("ab_restart_busy",  32'(bz[0]), 32'd1);

    // start+abort together in IDLE leaves the block idle.
    cleanup();
    st[0] = 1'b1;
    abort = 1'b1;
    tick();
    st[0] = 1'b0;
    abort = 1'b0;
    check("sa_busy",  32'(bz[0]), 32'd0);
    check("sa_valid", 32'(tv[0]), 32'd0);
    tick();
    check("sa_busy2", 32'(bz[0]), 32'd0);

    // start pulses during RUN are ignored; a start in the done cycle is taken.
    m_tready = 1'b1;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    hs = 0;
    cyc = 0;
    while (!dn[0] && cyc < 300) begin
      st[0] = (cyc == 20 || cyc == 50);
      if (tv[0] && m_tready) hs++;
      tick();
      cyc++;
    end
    st[0] = 1'b0;
    check("ig_handshakes", 32'(hs), 32'd80);
    check("ig_done_cycle", 32'(cyc), 32'd80);
    check("ig_done", 32'(dn[0]), 32'd1);
    check("ig_gap_valid", 32'(tv[0]), 32'd0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    check("b2b_valid", 32'(tv[0]), 32'd1);
    check("b2b_data",  td[0], 32'h02D402D4);
    check("b2b_busy",  32'(bz[0]), 32'd1);

    // Parameter sweep: N_REP = 1 and N_REP = 7.
    cleanup();
    burst_full(1, 16);
    burst_full(2, 112);

    // Asynchronous reset between clock edges in the middle of a burst.
    cleanup();
    m_tready = 1'b1;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (10) tick();
    #3 arst_n = 1'b0;
    #1;
    check("ar_valid", 32'(tv[0]), 32'd0);
    check("ar_data",  td[0],      32'd0);
    check("ar_last",  32'(tl[0]), 32'd0);
    check("ar_busy",  32'(bz[0]), 32'd0);
    check("ar_done",  32'(dn[0]), 32'd0);
    check("ar_addr",  32'(ra[0]), 32'd0);
    tick();
    #2 arst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dcnt += int'(dn[0]) + int'(tv[0]) + int'(bz[0]);
    end
    check("ar_idle_after", 32'(dcnt), 32'd0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    check("ar_restart_data", td[0], 32'h02D402D4);
    check("ar_restart_addr", 32'(ra[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
